// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } stage_state_e;

  // Wide enough for any realistic control bundle; sliced to CTRL_W at use.
  localparam int unsigned MaxCtrlW = 256;
  localparam logic [MaxCtrlW-1:0] NopCtrl = '0;

  function automatic logic accepts(stage_state_e s);
    return s != StTwo;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline register: a data word with a valid bit.
// Priority is clear > load > unload; clear also zeroes the stored word.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating output-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned SlotW = DATA_W + CTRL_W;

  logic             accept, emit;
  logic             main_load, main_unload, main_valid;
  logic [SlotW-1:0] in_bundle, main_d, main_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign in_bundle = {in_data, in_ctrl};
  assign accept    = in_valid & in_ready;
  assign emit      = main_valid & out_ready;

  pipe_slot #(
    .W(SlotW)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (flush),
    .load_i  (main_load),
    .unload_i(main_unload),
    .d_i     (main_d),
    .valid_o (main_valid),
    .q_o     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e     state_d, state_q;
      logic             in_ready_q;
      logic             skid_load, skid_unload, skid_valid;
      logic [SlotW-1:0] skid_q;

      always_comb begin
        state_d     = state_q;
        main_load   = 1'b0;
        main_unload = 1'b0;
        main_d      = in_bundle;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        if (flush) begin
          state_d = StEmpty;
        end else begin
          case (state_q)
            StEmpty: begin
              if (accept) begin
                state_d   = StOne;
                main_load = 1'b1;
              end
            end
            StOne: begin
              if (accept && emit) begin
                main_load = 1'b1;
              end else if (accept) begin
                state_d   = StTwo;
                skid_load = 1'b1;
              end else if (emit) begin
                state_d     = StEmpty;
                main_unload = 1'b1;
              end
            end
            StTwo: begin
              // Older entry sits in main, so the skid entry always follows it out.
              if (emit && skid_valid) begin
                state_d     = StOne;
                main_load   = 1'b1;
                main_d      = skid_q;
                skid_unload = 1'b1;
              end
            end
            default: state_d = StEmpty;
          endcase
        end
      end

      pipe_slot #(
        .W(SlotW)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .load_i  (skid_load),
        .unload_i(skid_unload),
        .d_i     (in_bundle),
        .valid_o (skid_valid),
        .q_o     (skid_q)
      );

      // in_ready is a flop so the upstream ready path does not see out_ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          in_ready_q <= accepts(state_d);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_single
      always_comb begin
        main_load   = accept;
        main_unload = emit;
        main_d      = in_bundle;
      end

      assign in_ready = ~main_valid | out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_q[SlotW-1:CTRL_W];
  assign out_ctrl  = main_valid ? main_q[CTRL_W-1:0] : NopCtrl[CTRL_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (main_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Runs a single-slot and a skid-buffered stage side by side on shared stimulus and
// compares both against a FIFO-of-capacity-N reference model every cycle.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, stat_clr;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;

  logic        ir0, ov0, ir1, ov1;
  logic [31:0] od0, od1;
  logic [15:0] oc0, oc1;
  logic [3:0]  sc0, sc1;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: bundles held by each stage in arrival order.
  int          m_n   [2];
  logic [47:0] m_e   [2][2];
  bit          m_zero[2];
  int          m_cnt [2];
  bit          m_live = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32),
    .CTRL_W(16),
    .SKID  (0),
    .CNT_W (4)
  ) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (ir0),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .out_valid   (ov0),
    .out_ready   (out_ready),
    .out_data    (od0),
    .out_ctrl    (oc0),
    .stat_clr    (stat_clr),
    .stall_cycles(sc0)
  );

  pipe_stage_reg #(
    .DATA_W(32),
    .CTRL_W(16),
    .SKID  (1),
    .CNT_W (4)
  ) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (ir1),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .out_valid   (ov1),
    .out_ready   (out_ready),
    .out_data    (od1),
    .out_ctrl    (oc1),
    .stat_clr    (stat_clr),
    .stall_cycles(sc1)
  );

  task automatic chk(input string tag, input int k, input logic [47:0] obs,
                     input logic [47:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input logic [15:0] c, input bit ordy,
                      input bit fl, input bit clr, input bit rst);
    bit val_e[2];
    bit rdy_e[2];
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    stat_clr  = clr;
    reset     = rst;
    #1;
    for (int k = 0; k < 2; k++) begin
      val_e[k] = m_n[k] > 0;
      rdy_e[k] = (k == 1) ? (m_n[k] < 2) : (m_n[k] == 0 || ordy);
      if (m_live) begin
        chk("out_valid", k, 48'(k == 1 ? ov1 : ov0), 48'(val_e[k]));
        chk("in_ready", k, 48'(k == 1 ? ir1 : ir0), 48'(rdy_e[k]));
        chk("out_ctrl", k, 48'(k == 1 ? oc1 : oc0),
            val_e[k] ? 48'(m_e[k][0][15:0]) : 48'd0);
        if (val_e[k]) begin
          chk("out_data", k, 48'(k == 1 ? od1 : od0), 48'(m_e[k][0][47:16]));
        end else if (m_zero[k]) begin
          chk("out_data_bubble", k, 48'(k == 1 ? od1 : od0), 48'd0);
        end
        chk("stall_cycles", k, 48'(k == 1 ? sc1 : sc0), 48'(m_cnt[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_n[k]    = 0;
        m_zero[k] = 1'b1;
        m_cnt[k]  = 0;
      end else if (m_live) begin
        if (clr) m_cnt[k] = 0;
        else if (val_e[k] && !ordy && m_cnt[k] < 15) m_cnt[k]++;
        if (fl) begin
          m_n[k]    = 0;
          m_zero[k] = 1'b1;
        end else begin
          if (val_e[k] && ordy) begin
            m_e[k][0] = m_e[k][1];
            m_n[k]--;
            m_zero[k] = 1'b0;
          end
          if (v && rdy_e[k]) begin
            m_e[k][m_n[k]] = {d, c};
            m_n[k]++;
            m_zero[k] = 1'b0;
          end
        end
      end
    end
    if (rst) m_live = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    stat_clr  = 1'b0;
    reset     = 1'b1;

    // Reset, then check the idle state.
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Streaming 1..8 with the sink always ready.
    for (int i = 1; i <= 8; i++) step(1, 32'(i), 16'h0001, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // Back-pressure: upstream keeps offering while the sink stalls, then drain.
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i), 16'h00A0 + 16'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);

    // Flush with both slots full and a live input in the flush cycle.
    step(1, 32'h200, 16'h0011, 0, 0, 0, 0);
    step(1, 32'h201, 16'h0012, 0, 0, 0, 0);
    step(1, 32'hDEAD, 16'hFFFF, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // Reset while holding one bundle under stall.
    step(1, 32'h300, 16'h0033, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Counter saturation, then clear while still stalled.
    step(1, 32'h400, 16'h0044, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // Random traffic with occasional flush, counter clear and reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
